// File: rtl/argon_pkg.sv
// Shared types for the master-bus initiator: unit IDs, bus words, queued move
// requests and the sequencer state encoding.
package argon_pkg;

    typedef logic [15:0] word_t;
    typedef logic [3:0]  unit_id_t;

    localparam unit_id_t UNIT_NONE = 4'h0;

    typedef struct packed {
        logic     imm;
        unit_id_t src;
        unit_id_t dst;
        word_t    data;
    } bus_req_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } bus_seq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO without fall-through; o_rdata presents the oldest entry
// whenever o_empty is low.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_master_seq.sv
// Master-bus initiator: queues unit-to-unit moves and runs each as a read phase
// (with timeout) followed by a single-cycle write phase.
//
//   state | meaning
//   IDLE  | bus quiet; pops the next queued request
//   READ  | o_read_id = src, waiting for i_rvalid or timeout
//   WRITE | one cycle: write strobe to dst (if any) and o_done
module bus_master_seq
    import argon_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_imm,
    input  logic [3:0]  i_req_src,
    input  logic [3:0]  i_req_dst,
    input  logic [15:0] i_req_data,
    output logic [3:0]  o_read_id,
    input  logic [15:0] i_rdata,
    input  logic        i_rvalid,
    output logic [3:0]  o_write_id,
    output logic [15:0] o_wdata,
    output logic        o_wvalid,
    output logic        o_done,
    output logic [15:0] o_done_data,
    output logic        o_err,
    output logic        o_busy
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);

    bus_seq_state_t r_state;
    unit_id_t       r_dst;
    logic [TW-1:0]  r_cnt;
    unit_id_t       r_read_id;
    unit_id_t       r_write_id;
    word_t          r_wdata;
    logic           r_wvalid;
    logic           r_done;
    word_t          r_done_data;

    bus_req_t          w_push_req;
    bus_req_t          w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic              w_push;
    logic              w_pop;
    logic              w_last_read;
    logic              w_enter_write;
    unit_id_t          w_wr_dst;
    word_t             w_wr_data;

    assign w_push_req = '{imm: i_req_imm, src: i_req_src, dst: i_req_dst, data: i_req_data};
    assign w_push     = i_req_valid && o_req_ready;
    assign w_pop      = (r_state == IDLE) && (w_count != '0);

    sync_fifo #(
        .WIDTH($bits(bus_req_t)),
        .DEPTH(DEPTH)
    ) u_req_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_push (w_push),
        .i_wdata(w_push_req),
        .i_pop  (w_pop),
        .o_rdata(w_head),
        .o_full (w_full),
        .o_empty(w_empty),
        .o_count(w_count)
    );

    // Write phase is entered either straight from IDLE (immediate) or from READ.
    assign w_last_read   = (r_cnt == TW'(TIMEOUT - 1));
    assign w_enter_write = ((r_state == IDLE) && w_pop && w_head.imm) ||
                           ((r_state == READ) && i_rvalid);
    assign w_wr_dst      = (r_state == IDLE) ? w_head.dst  : r_dst;
    assign w_wr_data     = (r_state == IDLE) ? w_head.data : i_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_dst       <= UNIT_NONE;
            r_cnt       <= '0;
            r_read_id   <= UNIT_NONE;
            r_write_id  <= UNIT_NONE;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_done      <= 1'b0;
            r_done_data <= '0;
        end else begin
            r_write_id  <= UNIT_NONE;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_done      <= 1'b0;
            r_done_data <= '0;
            if (w_enter_write) begin
                r_done      <= 1'b1;
                r_done_data <= w_wr_data;
                if (w_wr_dst != UNIT_NONE) begin
                    r_write_id <= w_wr_dst;
                    r_wdata    <= w_wr_data;
                    r_wvalid   <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_dst <= w_head.dst;
                        r_cnt <= '0;
                        if (w_head.imm) begin
                            r_state <= WRITE;
                        end else begin
                            r_state   <= READ;
                            r_read_id <= w_head.src;
                        end
                    end
                end
                READ: begin
                    if (i_rvalid || w_last_read) begin
                        r_state   <= i_rvalid ? WRITE : IDLE;
                        r_read_id <= UNIT_NONE;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                WRITE:   r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // The timeout pulse must coincide with the final READ cycle, so it depends on i_rvalid.
    assign o_err       = (r_state == READ) && !i_rvalid && w_last_read;
    assign o_req_ready = !w_full;
    assign o_busy      = (r_state != IDLE) || !w_empty;
    assign o_read_id   = r_read_id;
    assign o_write_id  = r_write_id;
    assign o_wdata     = r_wdata;
    assign o_wvalid    = r_wvalid;
    assign o_done      = r_done;
    assign o_done_data = r_done_data;

endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq: single-transfer vector table, reset and
// FIFO-full sequences, then randomized traffic against a cycle-schedule model.
module tb_bus_master_seq;

    localparam int DEPTH = 4;
    localparam int T     = 16;
    localparam int NR    = 1500;
    localparam int MAXC  = NR + 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_imm;
    logic [3:0]  req_src;
    logic [3:0]  req_dst;
    logic [15:0] req_data;
    logic [3:0]  read_id;
    logic [15:0] rdata;
    logic        rvalid;
    logic [3:0]  write_id;
    logic [15:0] wdata;
    logic        wvalid;
    logic        done;
    logic [15:0] done_data;
    logic        err;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    bus_master_seq #(.DEPTH(DEPTH), .TIMEOUT(T)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_imm  (req_imm),
        .i_req_src  (req_src),
        .i_req_dst  (req_dst),
        .i_req_data (req_data),
        .o_read_id  (read_id),
        .i_rdata    (rdata),
        .i_rvalid   (rvalid),
        .o_write_id (write_id),
        .o_wdata    (wdata),
        .o_wvalid   (wvalid),
        .o_done     (done),
        .o_done_data(done_data),
        .o_err      (err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic imm, input logic [3:0] src,
                             input logic [3:0] dst, input logic [15:0] data);
        req_valid = v;
        req_imm   = imm;
        req_src   = src;
        req_dst   = dst;
        req_data  = data;
    endtask

    typedef struct {
        logic        imm;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic [15:0] data;
        int          rdelay;     // READ cycle (0-based) carrying i_rvalid; -1 = never
        logic [15:0] rdata;
        int          exp_rd;     // cycles with o_read_id nonzero
        int          exp_end;    // cycle of o_done/o_err, push cycle = 0
        logic        exp_done;
        logic        exp_err;
        logic [15:0] exp_data;
        logic        exp_wv;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int          rd_n   = 0;
        int          end_c  = -1;
        logic        bad_id = 1'b0;
        logic        g_done = 1'b0;
        logic        g_err  = 1'b0;
        logic        g_wv   = 1'b0;
        logic        g_busy = 1'b1;
        logic [3:0]  g_wid  = 4'd0;
        logic [15:0] g_data = 16'd0;
        logic [15:0] g_wd   = 16'd0;
        next_cycle();
        drive_req(1'b1, v.imm, v.src, v.dst, v.data);
        @(negedge clk);
        chk($sformatf("vec%0d ready", idx), {31'd0, req_ready}, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            req_valid = 1'b0;
            rvalid    = 1'b0;
            rdata     = 16'($urandom);
            if (read_id != 4'd0) begin
                rd_n++;
                if (read_id != v.src) bad_id = 1'b1;
                if (v.rdelay >= 0 && rd_n == v.rdelay + 1) begin
                    rvalid = 1'b1;
                    rdata  = v.rdata;
                end
            end
            @(negedge clk);
            if (end_c < 0 && (done || err)) begin
                end_c  = k;
                g_done = done;
                g_err  = err;
                g_data = done_data;
                g_wv   = wvalid;
                g_wid  = write_id;
                g_wd   = wdata;
            end
            if (end_c >= 0 && k == end_c + 2) begin
                g_busy = busy;
                break;
            end
        end
        rvalid = 1'b0;
        chk($sformatf("vec%0d read_cycles", idx), rd_n, v.exp_rd);
        chk($sformatf("vec%0d read_id", idx), {31'd0, bad_id}, 32'd0);
        chk($sformatf("vec%0d end_cycle", idx), end_c, v.exp_end);
        chk($sformatf("vec%0d done", idx), {31'd0, g_done}, {31'd0, v.exp_done});
        chk($sformatf("vec%0d err", idx), {31'd0, g_err}, {31'd0, v.exp_err});
        chk($sformatf("vec%0d wvalid", idx), {31'd0, g_wv}, {31'd0, v.exp_wv});
        chk($sformatf("vec%0d write_id", idx), {28'd0, g_wid}, v.exp_wv ? {28'd0, v.dst} : 32'd0);
        if (v.exp_done) chk($sformatf("vec%0d done_data", idx), {16'd0, g_data}, {16'd0, v.exp_data});
        if (v.exp_wv)   chk($sformatf("vec%0d wdata", idx), {16'd0, g_wd}, {16'd0, v.exp_data});
        chk($sformatf("vec%0d busy_after", idx), {31'd0, g_busy}, 32'd0);
    endtask

    // Randomized-phase schedule: expected outputs per cycle, built when a request is accepted.
    logic [3:0]  e_rid  [MAXC];
    logic [3:0]  e_wid  [MAXC];
    logic        e_wv   [MAXC];
    logic        e_done [MAXC];
    logic        e_err  [MAXC];
    logic        e_fb   [MAXC];
    logic [15:0] e_data [MAXC];
    logic        d_rv   [MAXC];
    logic [15:0] d_rdata[MAXC];

    vec_t vecs[7];

    initial begin
        int          acc;
        int          n_err;
        int          err_c;
        logic        quiet_bad;
        logic [15:0] dq[$];
        logic [3:0]  wq[$];
        int          pops[$];
        int          free_at;
        int          occ;
        logic        exp_ready;
        logic        offer;

        vecs[0] = '{1'b0, 4'd3, 4'd5,  16'h0000,  0, 16'hBEEF,  1,  3, 1'b1, 1'b0, 16'hBEEF, 1'b1};
        vecs[1] = '{1'b1, 4'd0, 4'd0,  16'h1234, -1, 16'h0000,  0,  2, 1'b1, 1'b0, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 4'd7, 4'd2,  16'h0000, -1, 16'h0000, 16, 17, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{1'b0, 4'd7, 4'd2,  16'h0000, 15, 16'h00A5, 16, 18, 1'b1, 1'b0, 16'h00A5, 1'b1};
        vecs[4] = '{1'b0, 4'd9, 4'd0,  16'h0000,  4, 16'h5A5A,  5,  7, 1'b1, 1'b0, 16'h5A5A, 1'b0};
        vecs[5] = '{1'b1, 4'd3, 4'd15, 16'hFFFF, -1, 16'h0000,  0,  2, 1'b1, 1'b0, 16'hFFFF, 1'b1};
        vecs[6] = '{1'b0, 4'd1, 4'd4,  16'hDEAD,  2, 16'h0000,  3,  5, 1'b1, 1'b0, 16'h0000, 1'b1};

        rst    = 1'b1;
        rvalid = 1'b0;
        rdata  = 16'd0;
        drive_req(1'b0, 1'b0, 4'd0, 4'd0, 16'd0);
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("por ready", {31'd0, req_ready}, 32'd1);
        chk("por busy", {31'd0, busy}, 32'd0);
        chk("por outputs", {read_id, write_id, wdata, wvalid, done, err}, 32'd0);
        chk("por done_data", {16'd0, done_data}, 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset during READ with a second request queued behind it.
        next_cycle();
        drive_req(1'b1, 1'b0, 4'd6, 4'd1, 16'd0);
        next_cycle();
        drive_req(1'b1, 1'b1, 4'd0, 4'd3, 16'h7777);
        next_cycle();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst pre read_id", {28'd0, read_id}, 32'd6);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("rst during outputs", {read_id, write_id, wdata, wvalid, done, err}, 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst after outputs", {read_id, write_id, wdata, wvalid, done, err}, 32'd0);
        chk("rst after done_data", {16'd0, done_data}, 32'd0);
        chk("rst after ready", {31'd0, req_ready}, 32'd1);
        chk("rst after busy", {31'd0, busy}, 32'd0);
        quiet_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            if (read_id != 4'd0 || write_id != 4'd0 || done || err || busy) quiet_bad = 1'b1;
        end
        chk("rst flushed quiet", {31'd0, quiet_bad}, 32'd0);

        // FIFO full: timing-out head stalls five immediate requests.
        next_cycle();
        drive_req(1'b1, 1'b0, 4'd7, 4'd2, 16'd0);
        @(negedge clk);
        acc   = 0;
        n_err = 0;
        err_c = -1;
        for (int k = 1; k <= 120; k++) begin
            next_cycle();
            drive_req(acc < 5, 1'b1, 4'd0, 4'(acc + 1), 16'hC000 + 16'(acc));
            @(negedge clk);
            if (k == 5) begin
                chk("full ready_c5", {31'd0, req_ready}, 32'd0);
                chk("full accepted_c5", acc, 4);
            end
            if (k == 12) chk("full ready_c12", {31'd0, req_ready}, 32'd0);
            if (req_valid && req_ready) acc++;
            if (err) begin
                n_err++;
                err_c = k;
            end
            if (done) begin
                dq.push_back(done_data);
                wq.push_back(write_id);
            end
            if (dq.size() == 5) break;
        end
        req_valid = 1'b0;
        chk("full accepted", acc, 5);
        chk("full err_count", n_err, 1);
        chk("full err_cycle", err_c, 17);
        chk("full done_count", dq.size(), 5);
        for (int i = 0; i < dq.size(); i++) begin
            chk($sformatf("full order data%0d", i), {16'd0, dq[i]}, 32'h0000_C000 + 32'(i));
            chk($sformatf("full order wid%0d", i), {28'd0, wq[i]}, 32'(i + 1));
        end

        // Randomized traffic against a per-cycle schedule.
        for (int j = 0; j < MAXC; j++) begin
            e_rid[j] = 4'd0; e_wid[j] = 4'd0; e_wv[j] = 1'b0; e_done[j] = 1'b0;
            e_err[j] = 1'b0; e_fb[j] = 1'b0; e_data[j] = 16'd0;
            d_rv[j] = 1'b0; d_rdata[j] = 16'd0;
        end
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        free_at = 0;
        for (int c = 0; c < NR + 150; c++) begin
            next_cycle();
            while (pops.size() > 0 && pops[0] < c) void'(pops.pop_front());
            occ       = pops.size();
            exp_ready = (occ != DEPTH);
            offer     = (c < NR) && ($urandom_range(0, 99) < 45);
            drive_req(offer, $urandom_range(0, 9) < 3, 4'($urandom_range(1, 15)),
                      ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
                      16'($urandom));
            rvalid = d_rv[c] | ((e_rid[c] == 4'd0) && ($urandom_range(0, 3) == 0));
            rdata  = d_rv[c] ? d_rdata[c] : 16'($urandom);
            @(negedge clk);
            chk($sformatf("rnd c%0d ready", c), {31'd0, req_ready}, {31'd0, exp_ready});
            chk($sformatf("rnd c%0d read_id", c), {28'd0, read_id}, {28'd0, e_rid[c]});
            chk($sformatf("rnd c%0d write_id", c), {28'd0, write_id}, {28'd0, e_wid[c]});
            chk($sformatf("rnd c%0d wvalid", c), {31'd0, wvalid}, {31'd0, e_wv[c]});
            chk($sformatf("rnd c%0d done", c), {31'd0, done}, {31'd0, e_done[c]});
            chk($sformatf("rnd c%0d done_data", c), {16'd0, done_data}, {16'd0, e_data[c]});
            chk($sformatf("rnd c%0d err", c), {31'd0, err}, {31'd0, e_err[c]});
            chk($sformatf("rnd c%0d busy", c), {31'd0, busy}, {31'd0, e_fb[c] || (occ > 0)});
            if (!(e_done[c] && !e_wv[c]))
                chk($sformatf("rnd c%0d wdata", c), {16'd0, wdata}, e_wv[c] ? {16'd0, e_data[c]} : 32'd0);
            if (offer && exp_ready) begin
                int          p;
                int          w;
                int          d;
                logic [15:0] word;
                p = (free_at > c + 1) ? free_at : c + 1;
                pops.push_back(p);
                word = req_data;
                if (req_imm) begin
                    w       = p + 1;
                    free_at = p + 2;
                end else if ($urandom_range(0, 9) == 0) begin
                    for (int j = p + 1; j <= p + T; j++) e_rid[j] = req_src;
                    e_err[p + T] = 1'b1;
                    w       = -1;
                    free_at = p + T + 1;
                end else begin
                    d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T - 1))
                                                    : int'($urandom_range(0, 3));
                    for (int j = p + 1; j <= p + 1 + d; j++) e_rid[j] = req_src;
                    word = 16'($urandom);
                    d_rv[p + 1 + d]    = 1'b1;
                    d_rdata[p + 1 + d] = word;
                    w       = p + 2 + d;
                    free_at = w + 1;
                end
                if (w >= 0) begin
                    e_done[w] = 1'b1;
                    e_data[w] = word;
                    e_wid[w]  = req_dst;
                    e_wv[w]   = (req_dst != 4'd0);
                end
                for (int j = p + 1; j < free_at; j++) e_fb[j] = 1'b1;
            end
        end
        req_valid = 1'b0;
        rvalid    = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_seq.md
Name: bus_master_seq

Overview:
- Initiator end of the shared master bus; drives `read_id`/`write_id` and the data path that each unit's bus buffer decodes.
- Accepts unit-to-unit move requests from the control unit into a small request FIFO.
- Executes each request as a read phase (source unit drives data) followed by a one-cycle write phase (destination unit captures data), with a read timeout.
- Sits between the control/decode logic and the master bus interface.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- TIMEOUT, 16, max cycles spent in the read phase waiting for `i_rvalid` (≥2)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_req_valid  in  1  request offered
- o_req_ready  out  1  FIFO can accept a request
- i_req_imm  in  1  1 = use `i_req_data`, skip the read phase
- i_req_src  in  4  source unit ID (ignored when imm)
- i_req_dst  in  4  destination unit ID; 0 = no write
- i_req_data  in  word_t  immediate operand
- o_read_id  out  4  master bus read select; 0 = none
- i_rdata  in  word_t  data returned by the selected unit
- i_rvalid  in  1  `i_rdata` valid this cycle
- o_write_id  out  4  master bus write select; 0 = none
- o_wdata  out  word_t  data presented to the destination unit
- o_wvalid  out  1  write strobe
- o_done  out  1  one-cycle pulse: transfer complete
- o_done_data  out  word_t  transferred word, valid with `o_done`
- o_err  out  1  one-cycle pulse: read timeout
- o_busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Clocking: all state updates on the rising edge of `i_clk`. `i_reset` is synchronous, active-high, one clock.
- Unit ID 0 (UNIT_NONE) is never a valid unit. `word_t` is 16 bits.
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, timeout counter 0. `o_req_ready` is 1 in the first cycle after reset deasserts.
- Reset mid-transfer: the in-flight transfer is dropped and the FIFO is flushed. No `o_done` or `o_err` pulse is produced.
- FIFO push: push when `i_req_valid && o_req_ready`.
- FIFO full: `o_req_ready` = (count != DEPTH), a registered-count function only. When full, a push and a pop in the same cycle still deasserts ready.
- FIFO push and pop in the same cycle: count is unchanged.
- FIFO pop: pops only in IDLE and only when count > 0, based on the registered count. There is no fall-through, so a request pushed in cycle N is popped no earlier than cycle N+1.
- IDLE: all bus outputs 0. On pop, latch the request; next state is WRITE if imm, else READ.
- READ: `o_read_id` = src.
  - If `i_rvalid`: capture `i_rdata`, next state WRITE.
  - If not `i_rvalid`: `cnt++`.
  - If `cnt == TIMEOUT-1` and no `i_rvalid`: pulse `o_err` this cycle, next state IDLE. `i_rvalid` in the final cycle wins over timeout.
  - READ lasts 1 to TIMEOUT cycles.
- WRITE: exactly one cycle; next state IDLE.
  - If dst != 0: `o_write_id` = dst, `o_wdata` = latched word, `o_wvalid` = 1.
  - If dst == 0: `o_write_id`/`o_wvalid` stay 0 (read-only probe).
  - `o_done` = 1 and `o_done_data` = latched word in either case.
- `o_read_id` and `o_write_id` are never nonzero in the same cycle.
- `o_wdata` and `o_done_data` are 0 outside WRITE.
- `cnt` is cleared on entry to READ.
- Latency for a non-imm request with immediate `i_rvalid`: pushed at cycle 0, popped at cycle 1, READ at cycle 2, WRITE/`o_done` at cycle 3.
- Latency for an imm request: `o_done` at cycle 2.
- Back-to-back requests: one request completes per 3 cycles (imm: 2).

Decomposition:
- argon_pkg holds:
  - `unit_id_t` (`logic [3:0]`)
  - `UNIT_NONE` = 4'h0
  - `bus_req_t` packed struct {imm, src, dst, data}
  - FSM enum `bus_seq_state_t` {IDLE, READ, WRITE}
  - `word_t`, already present
- Sub-module `sync_fifo` (parameterised by width and DEPTH, synchronous active-high reset, full/empty/count outputs) holds `bus_req_t` entries.

Test Plan:
- Reset: assert `i_reset` 2 cycles mid-READ → next cycle all outputs 0, `o_req_ready`=1, `o_busy`=0, no `o_done`/`o_err`.
- Basic move: push {imm=0, src=3, dst=5}; unit 3 returns 16'hBEEF with `i_rvalid` in the first READ cycle → cycle 2 `o_read_id`=3; cycle 3 `o_write_id`=5, `o_wdata`=BEEF, `o_wvalid`=1, `o_done`=1, `o_done_data`=BEEF.
- Immediate with dst=0: push {imm=1, dst=0, data=16'h1234} → `o_read_id` never nonzero; 2 cycles later `o_done`=1 with `o_done_data`=1234 and `o_wvalid`=0.
- Timeout: push {src=7, dst=2}, never assert `i_rvalid` → `o_read_id`=7 for exactly 16 cycles, `o_err` pulses in the 16th, no write, FSM returns to IDLE.
- `i_rvalid` on last READ cycle: assert it in the 16th READ cycle with data 16'h00A5 → no `o_err`; write of 00A5 to dst follows.
- FIFO full: push 5 imm requests on consecutive cycles with the FSM stalled by a timing-out head → `o_req_ready`=0 after the 4th accepted; the 5th is held; all accepted requests complete in order.
